// File: rtl/cfg_pwm_timer.sv
// Programmable 16-bit PWM timer driven by a flat SPI config vector; returns live state as a flat status vector.
// Optional capture input is compiled in with CFG_PWM_TIMER_CAPTURE_EN.
//
// state  | meaning
// IDLE   | stopped, counter and prescaler held at 0
// RUN    | prescaler ticking, counter advancing and wrapping at PERIOD
// DONE   | one-shot finished, counter held at 0 until EN drops
module cfg_pwm_timer #(
   parameter int NUM_CFG    = 8,
   parameter int NUM_STATUS = 8,
   parameter int REG_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              ena,
   input  logic [NUM_CFG*REG_WIDTH-1:0]      config_regs,
`ifdef CFG_PWM_TIMER_CAPTURE_EN
   input  logic                              capture_in,
`endif
   output logic [NUM_STATUS*REG_WIDTH-1:0]   status_regs,
   output logic                              pwm_out,
   output logic                              irq
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [REG_WIDTH-1:0] w_ctrl;
   logic [REG_WIDTH-1:0] w_prescale;
   logic [15:0]          w_period;
   logic [15:0]          w_duty;
   logic                 w_en, w_oneshot, w_inv, w_clr, w_irq_en;

   assign w_ctrl     = config_regs[0*REG_WIDTH +: REG_WIDTH];
   assign w_prescale = config_regs[1*REG_WIDTH +: REG_WIDTH];
   assign w_period   = {config_regs[3*REG_WIDTH +: REG_WIDTH], config_regs[2*REG_WIDTH +: REG_WIDTH]};
   assign w_duty     = {config_regs[5*REG_WIDTH +: REG_WIDTH], config_regs[4*REG_WIDTH +: REG_WIDTH]};
   assign w_en       = w_ctrl[0];
   assign w_oneshot  = w_ctrl[1];
   assign w_inv      = w_ctrl[2];
   assign w_clr      = w_ctrl[3];
   assign w_irq_en   = w_ctrl[4];

   logic w_unused_ctrl;
   assign w_unused_ctrl = ^w_ctrl[REG_WIDTH-1:5];

   generate
      if (NUM_CFG > 6) begin : g_unused_cfg
         logic w_unused_cfg;
         assign w_unused_cfg = ^config_regs[NUM_CFG*REG_WIDTH-1:6*REG_WIDTH];
      end
   endgenerate

   logic [1:0]           r_state;
   logic [15:0]          r_cnt;
   logic [REG_WIDTH-1:0] r_pre;
   logic [7:0]           r_wraps;
   logic                 r_wrap;
   logic                 r_done;
   logic                 r_clr_q;
   logic                 r_pwm;
   logic                 r_irq;

   logic w_clr_edge;
   logic w_running;
   logic w_tick;
   logic w_capt;
   logic [15:0] w_cap;

   assign w_clr_edge = w_clr & ~r_clr_q;
   assign w_running  = (r_state == S_RUN);
   assign w_tick     = (r_pre == w_prescale);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pre   <= '0;
         r_wraps <= '0;
         r_wrap  <= 1'b0;
         r_done  <= 1'b0;
         r_clr_q <= 1'b0;
         r_pwm   <= 1'b0;
         r_irq   <= 1'b0;
      end else if (ena) begin
         r_clr_q <= w_clr;
         r_pwm   <= (w_running & (r_cnt < w_duty)) ^ w_inv;
         r_irq   <= w_irq_en & (r_wrap | r_done | w_capt);
         if (w_clr_edge) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_wraps <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               S_RUN: begin
                  if (!w_en) begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                     r_pre   <= '0;
                  end else if (w_tick) begin
                     r_pre <= '0;
                     // >= rather than == so a live PERIOD drop below the count wraps on the next tick
                     if (r_cnt >= w_period) begin
                        r_cnt  <= '0;
                        r_wrap <= 1'b1;
                        if (r_wraps != 8'hFF) r_wraps <= r_wraps + 8'd1;
                        if (w_oneshot) begin
                           r_state <= S_DONE;
                           r_done  <= 1'b1;
                        end
                     end else begin
                        r_cnt <= r_cnt + 16'd1;
                     end
                  end else begin
                     r_pre <= r_pre + 1'b1;
                  end
               end
               S_DONE: begin
                  r_cnt <= '0;
                  r_pre <= '0;
                  if (!w_en) r_state <= S_IDLE;
               end
               default: begin
                  r_cnt <= '0;
                  r_pre <= '0;
                  if (w_en) r_state <= S_RUN;
               end
            endcase
         end
      end
   end

`ifdef CFG_PWM_TIMER_CAPTURE_EN
   logic        r_cap_s1, r_cap_s2, r_cap_s2_q;
   logic        r_capt;
   logic [15:0] r_cap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap_s1   <= 1'b0;
         r_cap_s2   <= 1'b0;
         r_cap_s2_q <= 1'b0;
         r_capt     <= 1'b0;
         r_cap      <= '0;
      end else if (ena) begin
         r_cap_s1   <= capture_in;
         r_cap_s2   <= r_cap_s1;
         r_cap_s2_q <= r_cap_s2;
         if (w_clr_edge) begin
            r_capt <= 1'b0;
         end else if (r_cap_s2 & ~r_cap_s2_q & w_running) begin
            // r_cnt here is the pre-update count, even when the counter advances this edge
            r_cap  <= r_cnt;
            r_capt <= 1'b1;
         end
      end
   end

   assign w_capt = r_capt;
   assign w_cap  = r_cap;
`else
   assign w_capt = 1'b0;
   assign w_cap  = 16'd0;
`endif

   logic [6*REG_WIDTH-1:0] w_stat_all;
   assign w_stat_all = {w_cap[15:8], w_cap[7:0], r_wraps, r_cnt[15:8], r_cnt[7:0],
                        3'b000, w_capt, r_pwm, r_done, r_wrap, w_running};

   always_comb begin
      status_regs = '0;
      for (int k = 0; k < NUM_STATUS && k < 6; k++) begin
         status_regs[k*REG_WIDTH +: REG_WIDTH] = w_stat_all[k*REG_WIDTH +: REG_WIDTH];
      end
   end

   assign pwm_out = r_pwm;
   assign irq     = r_irq;

endmodule

// File: tb/tb_cfg_pwm_timer.sv
// Directed bench for cfg_pwm_timer; capture checks are built when CFG_PWM_TIMER_CAPTURE_EN is defined.
module tb_cfg_pwm_timer;

   logic        clk;
   logic        rst;
   logic        ena;
   logic [63:0] cfg;
   logic [63:0] status_regs;
   logic        pwm_out;
   logic        irq;
`ifdef CFG_PWM_TIMER_CAPTURE_EN
   logic        capture_in;
`endif

   int checks = 0;
   int errors = 0;

   cfg_pwm_timer #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .config_regs (cfg),
`ifdef CFG_PWM_TIMER_CAPTURE_EN
      .capture_in  (capture_in),
`endif
      .status_regs (status_regs),
      .pwm_out     (pwm_out),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_reg(input int k, input logic [7:0] v);
      cfg[k*8 +: 8] = v;
   endtask

   task automatic set16(input int k, input logic [15:0] v);
      cfg[k*8 +: 8]     = v[7:0];
      cfg[(k+1)*8 +: 8] = v[15:8];
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ctrl low for a cycle first so the following CLR is a fresh rising edge
   task automatic do_clr();
      set_reg(0, 8'h00);
      step(1);
      set_reg(0, 8'h08);
      step(1);
   endtask

   function automatic logic [15:0] st_cnt();
      return {status_regs[23:16], status_regs[15:8]};
   endfunction
   function automatic logic [15:0] st_cap();
      return {status_regs[47:40], status_regs[39:32]};
   endfunction
   function automatic logic [7:0] st_wraps();
      return status_regs[31:24];
   endfunction
   function automatic logic st_run();
      return status_regs[0];
   endfunction
   function automatic logic st_wrap();
      return status_regs[1];
   endfunction
   function automatic logic st_done();
      return status_regs[2];
   endfunction
   function automatic logic st_capt();
      return status_regs[4];
   endfunction

   initial begin
      logic [15:0] cnt_exp [8];
      logic        pwm_exp [8];
      cnt_exp = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3};
      pwm_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      ena = 1'b1;
      cfg = '0;
`ifdef CFG_PWM_TIMER_CAPTURE_EN
      capture_in = 1'b0;
`endif
      step(2);
      check("rst_stat_lo", status_regs[31:0], 32'h0);
      check("rst_stat_hi", status_regs[63:32], 32'h0);
      check("rst_pwm", {31'd0, pwm_out}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);

      // basic PWM: PERIOD=3, DUTY=2, no prescale
      rst = 1'b0;
      set_reg(1, 8'd0);
      set16(2, 16'd3);
      set16(4, 16'd2);
      set_reg(0, 8'h01);
      for (int i = 0; i < 8; i++) begin
         step(1);
         check($sformatf("basic_cnt%0d", i), {16'd0, st_cnt()}, {16'd0, cnt_exp[i]});
         check($sformatf("basic_pwm%0d", i), {31'd0, pwm_out}, {31'd0, pwm_exp[i]});
         if (i == 3) check("basic_nowrap", {31'd0, st_wrap()}, 32'd0);
         if (i == 4) check("basic_wrap", {31'd0, st_wrap()}, 32'd1);
      end
      check("basic_running", {31'd0, st_run()}, 32'd1);

      // async reset mid-run
      rst = 1'b1;
      #1;
      check("midrst_stat_lo", status_regs[31:0], 32'h0);
      check("midrst_stat_hi", status_regs[63:32], 32'h0);
      check("midrst_pwm", {31'd0, pwm_out}, 32'd0);
      check("midrst_irq", {31'd0, irq}, 32'd0);
      step(2);
      rst = 1'b0;
      step(1);
      check("resume_run", {31'd0, st_run()}, 32'd1);
      check("resume_cnt0", {16'd0, st_cnt()}, 32'd0);
      step(1);
      check("resume_cnt1", {16'd0, st_cnt()}, 32'd1);

      // prescale 2 + one-shot with interrupt
      do_clr();
      check("clr_wrap", {31'd0, st_wrap()}, 32'd0);
      set_reg(1, 8'd2);
      set16(2, 16'd1);
      set_reg(0, 8'h13);
      step(3);
      check("ps_cnt_p3", {16'd0, st_cnt()}, 32'd0);
      step(1);
      check("ps_cnt_p4", {16'd0, st_cnt()}, 32'd1);
      step(2);
      check("ps_cnt_p6", {16'd0, st_cnt()}, 32'd1);
      check("ps_irq_early", {31'd0, irq}, 32'd0);
      step(1);
      check("os_done", {31'd0, st_done()}, 32'd1);
      check("os_notrun", {31'd0, st_run()}, 32'd0);
      check("os_cnt", {16'd0, st_cnt()}, 32'd0);
      check("os_wraps", {24'd0, st_wraps()}, 32'd1);
      step(1);
      check("os_irq", {31'd0, irq}, 32'd1);
      check("os_pwm", {31'd0, pwm_out}, 32'd0);
      step(3);
      check("os_hold_done", {31'd0, st_done()}, 32'd1);
      check("os_hold_cnt", {16'd0, st_cnt()}, 32'd0);

      // duty extremes and inversion
      do_clr();
      set_reg(1, 8'd0);
      set16(2, 16'd5);
      set16(4, 16'd0);
      set_reg(0, 8'h01);
      step(3);
      check("d0_pwm_a", {31'd0, pwm_out}, 32'd0);
      check("d0_running", {31'd0, st_run()}, 32'd1);
      step(4);
      check("d0_pwm_b", {31'd0, pwm_out}, 32'd0);
      set16(4, 16'h0010);
      step(1);
      check("dbig_pwm_a", {31'd0, pwm_out}, 32'd1);
      step(6);
      check("dbig_pwm_b", {31'd0, pwm_out}, 32'd1);
      set_reg(0, 8'h05);
      step(1);
      check("dbig_inv_a", {31'd0, pwm_out}, 32'd0);
      step(4);
      check("dbig_inv_b", {31'd0, pwm_out}, 32'd0);
      set16(4, 16'd0);
      step(1);
      check("d0_inv", {31'd0, pwm_out}, 32'd1);
      set_reg(0, 8'h04);
      step(2);
      check("idle_inv_pwm", {31'd0, pwm_out}, 32'd1);
      check("idle_notrun", {31'd0, st_run()}, 32'd0);
      check("idle_cnt", {16'd0, st_cnt()}, 32'd0);
      set_reg(0, 8'h00);
      step(1);
      check("idle_pwm", {31'd0, pwm_out}, 32'd0);

      // PERIOD=0: wrap every tick, WRAPS saturates
      do_clr();
      set16(2, 16'd0);
      set_reg(0, 8'h01);
      step(255);
      check("wraps_254", {24'd0, st_wraps()}, 32'd254);
      step(1);
      check("wraps_255", {24'd0, st_wraps()}, 32'd255);
      step(44);
      check("wraps_sat", {24'd0, st_wraps()}, 32'd255);
      set_reg(0, 8'h09);
      step(1);
      check("clr_wraps", {24'd0, st_wraps()}, 32'd0);
      check("clr_wrapbit", {31'd0, st_wrap()}, 32'd0);
      check("clr_idle", {31'd0, st_run()}, 32'd0);
      step(1);
      check("clr_rerun", {31'd0, st_run()}, 32'd1);
      check("clr_rerun_wraps", {24'd0, st_wraps()}, 32'd0);
      step(1);
      check("clrhold_w1", {24'd0, st_wraps()}, 32'd1);
      step(3);
      check("clrhold_w4", {24'd0, st_wraps()}, 32'd4);

      // ena freeze at count 7
      do_clr();
      set16(2, 16'd40);
      set16(4, 16'd10);
      set_reg(0, 8'h01);
      step(8);
      check("frz_pre_cnt", {16'd0, st_cnt()}, 32'd7);
      ena = 1'b0;
      step(10);
      check("frz_cnt", {16'd0, st_cnt()}, 32'd7);
      check("frz_pwm", {31'd0, pwm_out}, 32'd1);
      check("frz_run", {31'd0, st_run()}, 32'd1);
      ena = 1'b1;
      step(1);
      check("frz_resume", {16'd0, st_cnt()}, 32'd8);
      step(10);
      check("cap_pre_cnt", {16'd0, st_cnt()}, 32'h12);
`ifdef CFG_PWM_TIMER_CAPTURE_EN
      capture_in = 1'b1;
      step(2);
      capture_in = 1'b0;
      step(3);
      check("cap_range", {31'd0, (st_cap() >= 16'h12) && (st_cap() <= 16'h14)}, 32'd1);
      check("cap_capt", {31'd0, st_capt()}, 32'd1);
`else
      step(5);
      check("nocap_val", {16'd0, st_cap()}, 32'd0);
      check("nocap_capt", {31'd0, st_capt()}, 32'd0);
`endif
      check("stat_hi_zero", {16'd0, status_regs[63:48]}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cfg_pwm_timer.md
Name: cfg_pwm_timer

Overview:
Programmable 16-bit PWM timer that consumes the flat config register vector produced by the SPI register bank. It returns its live state as the flat status register vector that the bank reads back over SPI. It sits directly downstream of the SPI register wrapper, in the same clock domain, so no config synchronisers are needed. It drives one PWM pin and one interrupt line.

Parameters:
NUM_CFG, 8, number of config registers in config_regs; must be >= 6.
NUM_STATUS, 8, number of status registers in status_regs; must be >= 4.
REG_WIDTH, 8, register width; fixed at 8, other values are unsupported.

Ports:
clk  input  1  system clock, the same clock as the SPI register bank.
rst  input  1  asynchronous, active-high reset.
ena  input  1  block enable; when 0, all sequential state holds.
config_regs  input  NUM_CFG*REG_WIDTH  flat config vector; register k occupies bits [8k+7:8k].
status_regs  output  NUM_STATUS*REG_WIDTH  flat status vector, same packing.
pwm_out  output  1  registered PWM output.
irq  output  1  registered interrupt, level type.

Behaviour:
Config map:
- 0 CTRL: b0 EN, b1 ONESHOT, b2 INV, b3 CLR, b4 IRQ_EN; other bits ignored.
- 1 PRESCALE.
- 2 PERIOD_LO, 3 PERIOD_HI.
- 4 DUTY_LO, 5 DUTY_HI.
- Registers 6 and up are ignored.

Status map:
- 0 STAT: b0 RUNNING, b1 WRAP (sticky), b2 DONE (sticky), b3 PWM, b4 CAPT; other bits 0.
- 1 CNT_LO, 2 CNT_HI.
- 3 WRAPS: 8-bit wrap count, saturates at 255.
- 4 CAP_LO, 5 CAP_HI.
- Registers 6 and up read 0.

Reset values:
- state IDLE; counter, prescaler, WRAPS, WRAP, DONE, CAPT all 0.
- pwm_out 0, irq 0.

Enable and clear:
- When ena=0, all registers hold. status_regs keeps reflecting the held values.
- CLR acts on its rising edge only: CTRL.b3 registered, edge = b3 & ~b3_q. On the edge: counter, prescaler, WRAP, DONE, CAPT and WRAPS clear, and state goes to IDLE. A CLR edge has priority over every other event in that cycle.

State machine: IDLE, RUN, DONE.
- IDLE: counter = 0, prescaler = 0. EN=1 → RUN on the next edge.
- RUN:
  - Prescaler counts 0..PRESCALE. Tick occurs when prescaler == PRESCALE; prescaler then returns to 0. PRESCALE=0 gives a tick every clk.
  - On a tick with counter >= PERIOD: counter := 0, WRAP := 1, WRAPS := min(WRAPS+1, 255). If ONESHOT=1, go to DONE.
  - On any other tick: counter := counter+1.
  - EN=0 → IDLE; the counter clears on entry to IDLE.
- DONE: counter holds 0, DONE=1. EN=0 → IDLE. EN held at 1 stays in DONE.
- RUNNING = (state == RUN).

Live config changes:
- PERIOD, DUTY and PRESCALE are sampled live every cycle.
- Writing PERIOD below the current count wraps the counter on the next tick.
- PERIOD=0 means a wrap on every tick.

PWM:
- raw = RUNNING & (counter < DUTY).
- pwm_out = registered (raw XOR INV). Latency is 1 clk after the counter updates.
- DUTY=0 → pwm_out constant INV.
- DUTY > PERIOD → pwm_out constant ~INV while running.
- In IDLE and DONE, pwm_out = INV.

Interrupt: irq = registered IRQ_EN & (WRAP | DONE | CAPT).

Optional Feature:
Macro CFG_PWM_TIMER_CAPTURE_EN.
- Defined:
  - Adds input port capture_in (1 bit, asynchronous), passed through a 2-flop synchroniser.
  - A rising edge of the synchronised signal while RUNNING latches the counter into CAP_LO/CAP_HI and sets CAPT (sticky).
  - If a capture coincides with a counter update, the pre-update value is captured.
- Undefined:
  - No capture_in port.
  - CAP_LO, CAP_HI and CAPT read constant 0; CAPT never raises irq.

Test Plan:
1. Reset check: assert rst mid-run with EN=1, PERIOD=3 → all of status_regs = 0, pwm_out=0, irq=0. After release, RUN resumes from count 0.
2. Basic PWM: PRESCALE=0, PERIOD=3, DUTY=2, EN=1 → counter sequence 0,1,2,3,0 and pwm_out pattern 1,1,0,0 repeating (period 4 clk). WRAP=1 after the first wrap.
3. Prescale and one-shot: PRESCALE=2, PERIOD=1, ONESHOT=1, IRQ_EN=1 → counter advances every 3 clk. DONE=1 and irq=1 after 6 clk ticks. Counter holds 0 and pwm_out=0.
4. Duty extremes and inversion: DUTY=0 → pwm_out stays 0. DUTY=0x0010 with PERIOD=0x0005 → pwm_out constant 1 while running. Setting INV=1 → both cases invert, and pwm_out=1 in IDLE.
5. CLR and saturation: run PERIOD=0 for 300 clk → WRAPS=255. Then toggle CLR 0→1 in the same cycle as a wrap tick → WRAPS=0, WRAP=0, state IDLE, then RUN again next edge (EN=1). Holding CLR at 1 causes no further clears.
6. ena freeze (and capture with macro): ena=0 for 10 clk at count 7 → counter stays 7, pwm_out holds. With the macro defined, a capture_in pulse at count 0x0012 → CAP = 0x0012 (within sync latency tolerance of +2 counts), CAPT=1.
